// File: rtl/onchip_mem_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_copy_master
// Brief    : Avalon-MM block COPY / FILL master for a single-port on-chip RAM,
//            with a running checksum of all written words.
// Revision : 1.0 - initial release
// ============================================================================
module onchip_mem_copy_master #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 14,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    length,
    input  logic [DATA_W-1:0]   fill_data,
    input  logic [DATA_W-1:0]   fill_step,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [LEN_W-1:0]    words_done,
    output logic [DATA_W-1:0]   checksum,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    output logic                avm_clken
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_rd   = 3'd1;
    localparam logic [2:0] c_st_wait = 3'd2;
    localparam logic [2:0] c_st_wr   = 3'd3;
    localparam logic [2:0] c_st_fin  = 3'd4;

    logic [2:0]        r_state;
    logic              r_mode;
    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_cur_src;
    logic [ADDR_W-1:0] r_cur_dst;
    logic [DATA_W-1:0] r_cur_fill;
    logic [DATA_W-1:0] r_fill_step;
    logic [1:0]        r_lat_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;
    logic [LEN_W-1:0]  r_words_done;
    logic [DATA_W-1:0] r_checksum;
    logic [ADDR_W-1:0] r_address;
    logic              r_cs;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic              w_last;

    assign w_last = ((r_words_done + LEN_W'(1)) == r_len);

    // Bus outputs are set on the edge that enters a state, so RD/WR cycles
    // are exactly the cycles the registered strobes are high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_mode       <= 1'b0;
            r_len        <= '0;
            r_cur_src    <= '0;
            r_cur_dst    <= '0;
            r_cur_fill   <= '0;
            r_fill_step  <= '0;
            r_lat_cnt    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_words_done <= '0;
            r_checksum   <= '0;
            r_address    <= '0;
            r_cs         <= 1'b0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    // done is high in the first IDLE cycle; a start there is dropped
                    if (start && !r_done) begin
                        r_mode       <= mode;
                        r_len        <= length;
                        r_cur_src    <= src_addr;
                        r_cur_dst    <= dst_addr;
                        r_cur_fill   <= fill_data;
                        r_fill_step  <= fill_step;
                        r_words_done <= '0;
                        r_checksum   <= '0;
                        r_aborted    <= 1'b0;
                        r_busy       <= 1'b1;
                        if (length == '0) begin
                            r_state <= c_st_fin;
                        end else if (mode) begin
                            r_state   <= c_st_wr;
                            r_address <= dst_addr;
                            r_cs      <= 1'b1;
                            r_write   <= 1'b1;
                            r_wdata   <= fill_data;
                        end else begin
                            r_state   <= c_st_rd;
                            r_address <= src_addr;
                            r_cs      <= 1'b1;
                            r_write   <= 1'b0;
                        end
                    end
                end
                c_st_rd: begin
                    r_cs    <= 1'b0;
                    r_write <= 1'b0;
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= c_st_fin;
                    end else begin
                        r_lat_cnt <= 2'(READ_LATENCY);
                        r_state   <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= c_st_fin;
                    end else if (r_lat_cnt == 2'd1) begin
                        r_wdata   <= avm_readdata;
                        r_address <= r_cur_dst;
                        r_cs      <= 1'b1;
                        r_write   <= 1'b1;
                        r_state   <= c_st_wr;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 2'd1;
                    end
                end
                c_st_wr: begin
                    r_words_done <= r_words_done + LEN_W'(1);
                    r_checksum   <= r_checksum + r_wdata;
                    r_cur_dst    <= r_cur_dst + ADDR_W'(1);
                    r_cur_src    <= r_cur_src + ADDR_W'(1);
                    r_cur_fill   <= r_cur_fill + r_fill_step;
                    if (abort || w_last) begin
                        r_aborted <= abort;
                        r_cs      <= 1'b0;
                        r_write   <= 1'b0;
                        r_state   <= c_st_fin;
                    end else if (r_mode) begin
                        r_address <= r_cur_dst + ADDR_W'(1);
                        r_wdata   <= r_cur_fill + r_fill_step;
                    end else begin
                        r_address <= r_cur_src + ADDR_W'(1);
                        r_write   <= 1'b0;
                        r_state   <= c_st_rd;
                    end
                end
                c_st_fin: begin
                    r_cs    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign aborted        = r_aborted;
    assign words_done     = r_words_done;
    assign checksum       = r_checksum;
    assign avm_address    = r_address;
    assign avm_chipselect = r_cs;
    assign avm_write      = r_write;
    assign avm_writedata  = r_wdata;
    assign avm_byteenable = {(DATA_W/8){1'b1}};
    assign avm_clken      = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_onchip_mem_copy_master
// Brief    : Scoreboard bench for onchip_mem_copy_master, with RAM models for
//            a READ_LATENCY=1 and a READ_LATENCY=2 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_copy_master;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int LW = 14;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          start2 = 1'b0;
    logic          mode = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] length = '0;
    logic [DW-1:0] fill_data = '0;
    logic [DW-1:0] fill_step = '0;

    logic busy, done, aborted, cs, wr, clken;
    logic [LW-1:0] words_done;
    logic [DW-1:0] checksum, wdata, rdata;
    logic [AW-1:0] addr;
    logic [3:0] be;

    logic busy2, done2, aborted2, cs2, wr2, clken2;
    logic [LW-1:0] words_done2;
    logic [DW-1:0] checksum2, wdata2, rdata2;
    logic [AW-1:0] addr2;
    logic [3:0] be2;

    logic [DW-1:0] mem1 [0:8191];
    logic [DW-1:0] mem2 [0:8191];
    logic [DW-1:0] q1a, q2a, q2b;
    logic          pl_en = 1'b0;
    logic          pl_sel = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    int  checks = 0;
    int  errors = 0;
    int  cyc_cnt = 0;
    int  cs_cnt = 0;
    int  t0 = 0;
    wr_t exp1[$];
    wr_t exp2[$];

    always #5 clk = ~clk;

    onchip_mem_copy_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_data(fill_data), .fill_step(fill_step), .abort(abort),
        .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
        .checksum(checksum), .avm_address(addr), .avm_chipselect(cs),
        .avm_write(wr), .avm_byteenable(be), .avm_writedata(wdata),
        .avm_readdata(rdata), .avm_clken(clken)
    );

    onchip_mem_copy_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .READ_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_data(fill_data), .fill_step(fill_step), .abort(abort),
        .busy(busy2), .done(done2), .aborted(aborted2), .words_done(words_done2),
        .checksum(checksum2), .avm_address(addr2), .avm_chipselect(cs2),
        .avm_write(wr2), .avm_byteenable(be2), .avm_writedata(wdata2),
        .avm_readdata(rdata2), .avm_clken(clken2)
    );

    // RAM models: unregistered q (1 cycle) and registered q (2 cycles)
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        q1a <= mem1[addr];
        q2a <= mem2[addr2];
        q2b <= q2a;
        if (cs && wr) mem1[addr] <= wdata;
        if (cs2 && wr2) mem2[addr2] <= wdata2;
        if (pl_en && !pl_sel) mem1[pl_addr] <= pl_data;
        if (pl_en && pl_sel) mem2[pl_addr] <= pl_data;
    end
    assign rdata  = q1a;
    assign rdata2 = q2b;

    always @(negedge clk) begin
        wr_t e;
        if (cs === 1'b1) cs_cnt++;
        if (cs === 1'b1 && wr === 1'b1) begin
            checks++;
            if (exp1.size() == 0) begin
                errors++;
                $display("FAIL wr1_unexpected addr=%0d data=%0d required=no write", addr, wdata);
            end else begin
                e = exp1.pop_front();
                if (addr !== e.a || wdata !== e.d) begin
                    errors++;
                    $display("FAIL wr1 addr=%0d data=%0d required addr=%0d data=%0d", addr, wdata, e.a, e.d);
                end
            end
        end
        if (cs2 === 1'b1 && wr2 === 1'b1) begin
            checks++;
            if (exp2.size() == 0) begin
                errors++;
                $display("FAIL wr2_unexpected addr=%0d data=%0d required=no write", addr2, wdata2);
            end else begin
                e = exp2.pop_front();
                if (addr2 !== e.a || wdata2 !== e.d) begin
                    errors++;
                    $display("FAIL wr2 addr=%0d data=%0d required addr=%0d data=%0d", addr2, wdata2, e.a, e.d);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input bit which, input int n, input int seed);
        for (int i = 0; i < n; i++) begin
            pl_sel  = which;
            pl_en   = 1'b1;
            pl_addr = AW'(i);
            pl_data = DW'(seed * (i + 1));
            step();
        end
        pl_en = 1'b0;
    endtask

    task automatic issue(input bit which, input bit m, input int s, input int d,
                         input int len, input int fd, input int fs);
        mode      = m;
        src_addr  = AW'(s);
        dst_addr  = AW'(d);
        length    = LW'(len);
        fill_data = DW'(fd);
        fill_step = DW'(fs);
        t0        = cyc_cnt;
        if (which) start2 = 1'b1; else start = 1'b1;
        step();
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic push(input bit which, input int a, input int d);
        wr_t e;
        e.a = AW'(a);
        e.d = DW'(d);
        if (which) exp2.push_back(e); else exp1.push_back(e);
    endtask

    task automatic run_to(input int rel);
        for (int i = 0; i < 100 && (cyc_cnt - t0) < rel; i++) step();
    endtask

    // Returns at the negedge of the done cycle with the done cycle index checked.
    task automatic wait_done(input bit which, input int exp_rel, input string nm);
        int rel;
        rel = -1;
        for (int i = 0; i < 300 && rel < 0; i++) begin
            @(negedge clk);
            if ((which ? done2 : done) === 1'b1) rel = cyc_cnt - t0;
        end
        checks++;
        if (rel != exp_rel) begin
            errors++;
            $display("FAIL %s_done_cycle got=%0d required=%0d (-1 = timeout)", nm, rel, exp_rel);
        end
    endtask

    task automatic check_status(input string nm, input int wd, input int cks, input bit ab);
        checks++;
        if (words_done !== LW'(wd) || checksum !== DW'(cks) || aborted !== ab || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_status words=%0d cksum=%0d aborted=%0b busy=%0b required %0d %0d %0b 0",
                     nm, words_done, checksum, aborted, busy, wd, cks, ab);
        end
    endtask

    task automatic check_drained(input string nm);
        checks++;
        if (exp1.size() != 0 || exp2.size() != 0) begin
            errors++;
            $display("FAIL %s_pending_writes got=%0d/%0d required=0/0", nm, exp1.size(), exp2.size());
        end
    endtask

    task automatic test_reset();
        step();
        step();
        @(negedge clk);
        checks++;
        if ({busy, done, aborted, words_done, checksum, addr, cs, wr, wdata} !== '0 ||
            {busy2, done2, aborted2, words_done2, checksum2, addr2, cs2, wr2, wdata2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%0b done=%0b wd=%0d cks=%0d cs=%0b required all 0",
                     busy, done, words_done, checksum, cs);
        end
        checks++;
        if (be !== 4'hf || clken !== 1'b1 || be2 !== 4'hf || clken2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_constants be=%h clken=%0b required be=f clken=1", be, clken);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_copy();
        preload(0, 4, 11);
        issue(0, 0, 0, 100, 4, 0, 0);
        for (int i = 0; i < 4; i++) push(0, 100 + i, 11 * (i + 1));
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL copy_busy got=%0b required=1", busy);
        end
        wait_done(0, 14, "copy");
        check_status("copy", 4, 110, 0);
        step();
        check_drained("copy");
    endtask

    task automatic test_fill();
        issue(0, 1, 0, 8190, 4, 5, 3);
        push(0, 8190, 5);
        push(0, 8191, 8);
        push(0, 0, 11);
        push(0, 1, 14);
        wait_done(0, 6, "fill");
        check_status("fill", 4, 38, 0);
        step();
        check_drained("fill");
    endtask

    task automatic test_zero_len();
        int cs_before;
        cs_before = cs_cnt;
        issue(0, 0, 0, 50, 0, 0, 0);
        wait_done(0, 2, "zero");
        check_status("zero", 0, 0, 0);
        checks++;
        if (cs_cnt != cs_before) begin
            errors++;
            $display("FAIL zero_chipselect got=%0d cycles required=0", cs_cnt - cs_before);
        end
        step();
    endtask

    task automatic test_abort();
        preload(0, 10, 7);
        issue(0, 0, 0, 200, 10, 0, 0);
        push(0, 200, 7);
        push(0, 201, 14);
        run_to(8);
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_done(0, 10, "abort_wait");
        check_status("abort_wait", 2, 21, 1);
        step();
        check_drained("abort_wait");

        issue(0, 0, 0, 220, 10, 0, 0);
        for (int i = 0; i < 3; i++) push(0, 220 + i, 7 * (i + 1));
        run_to(9);
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_done(0, 11, "abort_wr");
        check_status("abort_wr", 3, 42, 1);
        step();
        check_drained("abort_wr");
    endtask

    task automatic test_back_to_back();
        issue(0, 0, 0, 300, 4, 0, 0);
        for (int i = 0; i < 4; i++) push(0, 300 + i, 7 * (i + 1));
        run_to(3);
        dst_addr = AW'(400);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(0, 14, "busy_start");
        check_status("busy_start", 4, 70, 0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cs !== 1'b0) begin
            errors++;
            $display("FAIL start_on_done busy=%0b cs=%0b required 0 0", busy, cs);
        end
        step();
        check_drained("busy_start");
    endtask

    task automatic test_reset_mid();
        bit seen;
        issue(0, 0, 0, 500, 4, 0, 0);
        push(0, 500, 7);
        run_to(5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, aborted, words_done, checksum, cs, wr} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs busy=%0b done=%0b wd=%0d cks=%0d cs=%0b required all 0",
                     busy, done, words_done, checksum, cs);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midreset_done got=1 required=0");
        end
        check_drained("midreset");
        step();
        issue(0, 0, 0, 600, 2, 0, 0);
        push(0, 600, 7);
        push(0, 601, 14);
        wait_done(0, 8, "after_reset");
        check_status("after_reset", 2, 21, 0);
        step();
        check_drained("after_reset");
    endtask

    task automatic test_latency2();
        preload(1, 4, 11);
        issue(1, 0, 0, 100, 4, 0, 0);
        for (int i = 0; i < 4; i++) push(1, 100 + i, 11 * (i + 1));
        wait_done(1, 18, "lat2");
        checks++;
        if (words_done2 !== LW'(4) || checksum2 !== DW'(110) || aborted2 !== 1'b0) begin
            errors++;
            $display("FAIL lat2_status words=%0d cksum=%0d aborted=%0b required 4 110 0",
                     words_done2, checksum2, aborted2);
        end
        step();
        check_drained("lat2");
    endtask

    initial begin
        test_reset();
        test_copy();
        test_fill();
        test_zero_len();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_latency2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
